// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared constants and types.
// Beat geometry, FSM encoding and client ids.
package mem_arbiter_pkg;

  localparam int MEM_DATA_BITS = 128;
  localparam int MEM_ADDR_BITS = 28;
  localparam int MEM_MASK_BITS = MEM_DATA_BITS / 8;
  localparam int READ_BEATS    = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_READ_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    CLIENT_IC = 1'b0,
    CLIENT_DC = 1'b1
  } client_e;

  localparam logic [1:0] LAST_BEAT = 2'(READ_BEATS - 1);

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-request round-robin picker.
// Purely combinational; ties go to the client not granted last.
module mem_arbiter_rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  client_e    last_grant,
  output client_e    gnt,
  output logic       any
);

  always_comb begin
    gnt = last_grant;
    any = |req;
    unique case (1'b1)
      (req == 2'b11): gnt = (last_grant == CLIENT_IC) ? CLIENT_DC : CLIENT_IC;
      (req == 2'b01): gnt = CLIENT_IC;
      (req == 2'b10): gnt = CLIENT_DC;
      default:        gnt = last_grant;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client (ic/dc) arbiter for the shared off-chip memory port.
// One transaction at a time; read beats steered to the read owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     ic_req_valid,
  output logic                     ic_req_ready,
  input  logic [MEM_ADDR_BITS-1:0] ic_req_addr,
  input  logic                     ic_req_rw,
  input  logic                     ic_req_data_valid,
  output logic                     ic_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] ic_req_data_bits,
  input  logic [MEM_MASK_BITS-1:0] ic_req_data_mask,
  output logic                     ic_resp_valid,
  output logic [MEM_DATA_BITS-1:0] ic_resp_data,

  input  logic                     dc_req_valid,
  output logic                     dc_req_ready,
  input  logic [MEM_ADDR_BITS-1:0] dc_req_addr,
  input  logic                     dc_req_rw,
  input  logic                     dc_req_data_valid,
  output logic                     dc_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] dc_req_data_bits,
  input  logic [MEM_MASK_BITS-1:0] dc_req_data_mask,
  output logic                     dc_resp_valid,
  output logic [MEM_DATA_BITS-1:0] dc_resp_data,

  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  output logic                     mem_req_rw,
  output logic                     mem_req_data_valid,
  input  logic                     mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
  output logic [MEM_MASK_BITS-1:0] mem_req_data_mask,
  input  logic                     mem_resp_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_resp_data
);

  state_e     state_q, state_d;
  client_e    owner_q, owner_d;
  client_e    last_q, last_d;
  logic       req_done_q, req_done_d;
  logic       data_done_q, data_done_d;
  logic [1:0] beat_q, beat_d;

  client_e pick_gnt;
  logic    pick_any;
  client_e sel;
  logic    granted;

  logic                     sel_valid;
  logic                     sel_rw;
  logic                     sel_dvalid;
  logic                     req_hs;
  logic                     data_hs;
  logic                     rd_active;

  mem_arbiter_rr_pick2 u_pick (
    .req        ({dc_req_valid, ic_req_valid}),
    .last_grant (last_q),
    .gnt        (pick_gnt),
    .any        (pick_any)
  );

  // Grant is live in IDLE (picker) and locked to owner in WRITE.
  always_comb begin
    granted = 1'b0;
    sel     = owner_q;
    if (!reset) begin
      unique case (state_q)
        ST_IDLE: begin
          granted = pick_any;
          sel     = pick_gnt;
        end
        ST_WRITE: granted = 1'b1;
        default:  granted = 1'b0;
      endcase
    end
  end

  always_comb begin
    if (sel == CLIENT_DC) begin
      sel_valid         = dc_req_valid;
      sel_rw            = dc_req_rw;
      sel_dvalid        = dc_req_data_valid;
      mem_req_addr      = dc_req_addr;
      mem_req_data_bits = dc_req_data_bits;
      mem_req_data_mask = dc_req_data_mask;
    end else begin
      sel_valid         = ic_req_valid;
      sel_rw            = ic_req_rw;
      sel_dvalid        = ic_req_data_valid;
      mem_req_addr      = ic_req_addr;
      mem_req_data_bits = ic_req_data_bits;
      mem_req_data_mask = ic_req_data_mask;
    end
  end

  assign mem_req_rw         = sel_rw;
  assign mem_req_valid      = granted && sel_valid && !req_done_q;
  assign mem_req_data_valid = granted && sel_dvalid && sel_rw
                              && !data_done_q;

  assign ic_req_ready = granted && (sel == CLIENT_IC)
                        && mem_req_ready && !req_done_q;
  assign dc_req_ready = granted && (sel == CLIENT_DC)
                        && mem_req_ready && !req_done_q;

  assign ic_req_data_ready = granted && (sel == CLIENT_IC)
                             && mem_req_data_ready && !data_done_q;
  assign dc_req_data_ready = granted && (sel == CLIENT_DC)
                             && mem_req_data_ready && !data_done_q;

  assign req_hs  = mem_req_valid && mem_req_ready;
  assign data_hs = mem_req_data_valid && mem_req_data_ready;

  // Beats outside READ_WAIT carry no owner and are discarded.
  assign rd_active     = !reset && (state_q == ST_READ_WAIT) && mem_resp_valid;
  assign ic_resp_valid = rd_active && (owner_q == CLIENT_IC);
  assign dc_resp_valid = rd_active && (owner_q == CLIENT_DC);
  assign ic_resp_data  = mem_resp_data;
  assign dc_resp_data  = mem_resp_data;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    req_done_d  = req_done_q;
    data_done_d = data_done_q;
    beat_d      = beat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_hs && !sel_rw) begin
          state_d = ST_READ_WAIT;
          owner_d = sel;
          last_d  = sel;
          beat_d  = 2'd0;
        end else if (req_hs && data_hs) begin
          last_d = sel;
        end else if (req_hs || data_hs) begin
          state_d     = ST_WRITE;
          owner_d     = sel;
          last_d      = sel;
          req_done_d  = req_hs;
          data_done_d = data_hs;
        end
      end
      ST_WRITE: begin
        if ((req_done_q || req_hs) && (data_done_q || data_hs)) begin
          state_d     = ST_IDLE;
          req_done_d  = 1'b0;
          data_done_d = 1'b0;
        end else begin
          req_done_d  = req_done_q || req_hs;
          data_done_d = data_done_q || data_hs;
        end
      end
      ST_READ_WAIT: begin
        if (mem_resp_valid) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_IDLE;
            beat_d  = 2'd0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= CLIENT_IC;
      last_q      <= CLIENT_DC;
      req_done_q  <= 1'b0;
      data_done_q <= 1'b0;
      beat_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      req_done_q  <= req_done_d;
      data_done_q <= data_done_d;
      beat_q      <= beat_d;
    end
  end

endmodule
